// File: rtl/sha_padder.sv
// FIPS 180-4 message padder in front of sha_engine.
// Packs a byte stream into blocks and appends the 0x80 marker and bit length.
package sha;
    typedef enum logic [2:0] {
        sha1, sha224, sha256, sha384, sha512, sha512_224, sha512_256
    } mode_t;
endpackage

module sha_padder
    import sha::*;
#(
    parameter int IN_BYTES = 8,
    parameter int LEN_W    = 64
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [IN_BYTES*8-1:0]       s_data,
    input  logic                        s_last,
    input  logic [$clog2(IN_BYTES):0]   s_bytes,
    input  mode_t                       s_mode,
    output logic                        new_msg,
    output logic                        valid,
    output mode_t                       mode,
    output logic [1023:0]               msg,
    input  logic                        ready
);
    localparam int DW = IN_BYTES * 8;
    localparam int TW = LEN_W - 3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FILL, ST_SEND, ST_PAD_SEND, ST_LEN_SEND
    } state_t;

    typedef enum logic [1:0] {PD_NONE, PD_LEN, PD_PADLEN} pend_t;

    state_t          state_q, state_n;
    pend_t           pend_q, pend_n;
    logic [7:0]      off_q, off_n;
    logic [TW-1:0]   total_q, total_n;
    logic            first_q, first_n;
    logic [1023:0]   blk_n;
    mode_t           mode_n;

    logic            w, wl, busy_n;
    logic [7:0]      bsz, lsz, base, off_c, nb, new_off;
    logic [TW-1:0]   tot_c, tot_new;
    logic [6:0]      idx;
    logic [DW-1:0]   data;

    function automatic logic wide(mode_t m);
        return m inside {sha384, sha512, sha512_224, sha512_256};
    endfunction

    // Length sits in the low 8 or 16 bytes of the block, big-endian.
    function automatic logic [1023:0] put_len(logic [1023:0] b, logic wd,
                                              logic [TW-1:0] tot);
        logic [LEN_W-1:0] l;
        l = {tot, 3'b000};
        if (wd) b[127:0] = 128'(l);
        else    b[63:0]  = 64'(l);
        return b;
    endfunction

    always_comb begin
        state_n = state_q;
        pend_n  = pend_q;
        off_n   = off_q;
        total_n = total_q;
        first_n = first_q;
        mode_n  = mode;
        blk_n   = msg;
        idx     = '0;
        wl      = wide(mode);
        w       = wide((state_q == ST_IDLE) ? s_mode : mode);
        bsz     = w ? 8'd128 : 8'd64;
        lsz     = w ? 8'd16 : 8'd8;
        base    = w ? 8'd0 : 8'd64;
        off_c   = (state_q == ST_IDLE) ? 8'd0 : off_q;
        tot_c   = (state_q == ST_IDLE) ? '0 : total_q;
        nb      = s_last ? 8'(s_bytes) : 8'(IN_BYTES);
        new_off = off_c + nb;
        tot_new = tot_c + TW'(nb);
        data    = s_data;
        for (int i = 0; i < IN_BYTES; i++)
            if (s_last && 8'(i) >= nb) data[DW-1-8*i -: 8] = '0;

        unique case (state_q)
            ST_IDLE, ST_FILL: begin
                if (s_valid && s_ready) begin
                    if (state_q == ST_IDLE) begin
                        mode_n  = s_mode;
                        first_n = 1'b1;
                    end
                    idx = 7'(8'd127 - (base + off_c));
                    blk_n[{idx, 3'b111} -: DW] = data;
                    off_n   = new_off;
                    total_n = tot_new;
                    state_n = ST_FILL;
                    if (new_off == bsz) begin
                        // Full block; a last word defers padding to the next one.
                        state_n = ST_SEND;
                        off_n   = '0;
                        pend_n  = s_last ? PD_PADLEN : PD_NONE;
                    end else if (s_last) begin
                        idx = 7'(8'd127 - (base + new_off));
                        blk_n[{idx, 3'b111} -: 8] = 8'h80;
                        off_n = '0;
                        if (new_off + lsz < bsz) begin
                            blk_n   = put_len(blk_n, w, tot_new);
                            state_n = ST_PAD_SEND;
                        end else begin
                            state_n = ST_SEND;
                            pend_n  = PD_LEN;
                        end
                    end
                end
            end
            ST_SEND: begin
                if (ready) begin
                    first_n = 1'b0;
                    blk_n   = '0;
                    if (pend_q == PD_NONE) begin
                        state_n = ST_FILL;
                    end else begin
                        if (pend_q == PD_PADLEN)
                            blk_n[wl ? 10'd1023 : 10'd511 -: 8] = 8'h80;
                        blk_n   = put_len(blk_n, wl, total_q);
                        pend_n  = PD_NONE;
                        state_n = ST_LEN_SEND;
                    end
                end
            end
            ST_PAD_SEND, ST_LEN_SEND: begin
                if (ready) begin
                    first_n = 1'b0;
                    blk_n   = '0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        busy_n = state_n inside {ST_SEND, ST_PAD_SEND, ST_LEN_SEND};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            pend_q  <= PD_NONE;
            off_q   <= '0;
            total_q <= '0;
            first_q <= 1'b0;
            msg     <= '0;
            mode    <= sha1;
            valid   <= 1'b0;
            s_ready <= 1'b0;
            new_msg <= 1'b0;
        end else begin
            state_q <= state_n;
            pend_q  <= pend_n;
            off_q   <= off_n;
            total_q <= total_n;
            first_q <= first_n;
            msg     <= blk_n;
            mode    <= mode_n;
            valid   <= busy_n;
            s_ready <= !busy_n;
            new_msg <= busy_n && first_n;
        end
    end
endmodule

// File: doc/sha_padder.md
Name: sha_padder

Overview:
- Hardware message padder that sits in front of sha_engine. It takes a byte stream with valid/ready handshake and a last marker, then emits complete FIPS 180-4 padded blocks on the engine's new_msg/valid/mode/msg/ready interface.
- Software and benches no longer pre-pad messages.
- Supports every sha::mode_t, a parametrised input word width, and correct 64-bit and 128-bit length fields, including the extra length-only block.

Parameters:
- IN_BYTES, 8, bytes per input word. Power of two, 1..64. Must divide 64.
- LEN_W, 64, width of the internal bit-length counter. The length field is (bytes*8) mod 2^LEN_W, zero-extended to 64 or 128 bits.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  padder can accept a word.
- s_data  in  IN_BYTES*8  message bytes; first byte in the MSBs.
- s_last  in  1  word is the final word of the message.
- s_bytes  in  clog2(IN_BYTES)+1  valid bytes in the last word, 0..IN_BYTES. Ignored unless s_last.
- s_mode  in  sha::mode_t  mode, sampled on the first word of a message.
- new_msg  out  1  block is the first block of a message.
- valid  out  1  block valid to the engine.
- mode  out  sha::mode_t  latched message mode.
- msg  out  1024  block. 512-bit modes use msg[511:0] with msg[1023:512]=0.
- ready  in  1  engine ready; a block transfers on a rising edge with valid&&ready.

Behaviour:
- Block size B and length-field size L:
  - sha1/sha224/sha256: B=64, L=8.
  - sha384/sha512/sha512_224/sha512_256: B=128, L=16.
- Reset (asynchronous) values: s_ready=0, valid=0, new_msg=0, msg=0, mode=sha::sha1. All counters cleared, state ST_IDLE.
  - On the first clock after reset release, s_ready=1.
  - Reset mid-message discards all buffered data. No partial block is ever emitted.
- States: ST_IDLE, ST_FILL, ST_SEND, ST_PAD_SEND, ST_LEN_SEND.
- ST_IDLE:
  - s_ready=1.
  - An accepted word latches s_mode, sets the first flag, clears the byte counter, writes the word at offset 0, and moves to ST_FILL. If that word has s_last, the FILL rules below apply in the same cycle.
- ST_FILL:
  - s_ready=1.
  - Each accepted word is written at byte offset off, MSB-first: msg[B*8-1-8*off -: IN_BYTES*8]. off then advances by IN_BYTES, or by s_bytes on the last word.
  - Bytes beyond s_bytes in the last word are masked to 0.
  - When off reaches B on a non-last word: go to ST_SEND.
- Last word handling, with t = final off mod B and length = total bytes*8:
  - If t==0 and the message is non-empty with a full block pending: send that block (ST_SEND). The next block is 0x80 at byte 0 plus the length field (ST_LEN_SEND path).
  - If t <= B-L-1: write 0x80 at byte t and the length in the low L bytes (big-endian), then go to ST_PAD_SEND as the final block.
  - If B-L <= t <= B-1: write 0x80 at byte t, emit that block, then emit a block that is zero except for the length field (ST_LEN_SEND).
  - Empty message (first word has s_last and s_bytes=0): a single block with 0x80 at byte 0 and a zero length.
- ST_SEND, ST_PAD_SEND, ST_LEN_SEND:
  - valid=1 and s_ready=0.
  - msg, mode and new_msg are held stable until ready.
  - new_msg=1 only on the first block of the message.
  - On transfer:
    - the buffer clears;
    - from ST_SEND go to ST_FILL, or to the pending pad/len block;
    - after the final block go to ST_IDLE.
- Latency: valid rises on the clock edge after the word that completes a block. The next s_ready follows one cycle after the final transfer.
- No combinational path from ready to s_ready. s_ready is registered.
- s_mode changes mid-message are ignored.
- The byte counter wraps modulo 2^(LEN_W-3). The length field is truncated accordingly.

Test Plan:
- "abc", sha256, IN_BYTES=8 -> one block:
  - msg[511:480]=32'h61626380;
  - msg[63:0]=64'h18;
  - all other bits 0; new_msg=1.
- "Hello World!", sha512 -> one 1024-bit block:
  - top 13 bytes 48656c6c6f20576f726c642180;
  - msg[127:0]=128'h60.
- 56-byte message, sha256 -> two blocks:
  - block 0: bytes then 0x80 at byte 56, rest zero, new_msg=1;
  - block 1: only msg[63:0]=64'h1C0, new_msg=0.
- 128-byte message, sha384 -> two blocks:
  - block 0: data only;
  - block 1: msg[1023:1016]=8'h80, msg[127:0]=128'h400.
- Backpressure: hold ready=0 for 5 cycles during a block -> valid, msg and new_msg are stable and s_ready=0 throughout. The transfer happens on the first cycle ready=1.
- Reset: assert rstn=0 mid-ST_FILL, then send an empty sha1 message -> outputs clear immediately. A single block follows with msg[511:504]=8'h80 and all else 0.
